// File: rtl/adc_bitslip_train_pkg.sv
// Shared definitions for the ADC lane word-alignment trainer.
// The TAP state is only present when ADC_TRAIN_TAPSCAN_EN is defined.
package adc_bitslip_train_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_CHECK  = 3'd2,
    ST_SLIP   = 3'd3,
`ifdef ADC_TRAIN_TAPSCAN_EN
    ST_TAP    = 3'd4,
`endif
    ST_LOCKED = 3'd5,
    ST_FAIL   = 3'd6
  } train_state_e;

  localparam int         DEF_DATA_W        = 4;
  localparam logic [3:0] DEF_TRAIN_PATTERN = 4'b0011;
  localparam int         DEF_SLIP_WAIT     = 3;
  localparam int         DEF_MATCH_CNT     = 16;

endpackage

// File: rtl/adc_match_cnt.sv
// Consecutive-match counter: clears on a mismatch or on clr, saturates at
// MATCH_CNT and reports hit while saturated.
module adc_match_cnt #(
  parameter int MATCH_CNT = 16
) (
  input  logic adc_clk_bufr,
  input  logic rst_sync_n,
  input  logic clr,
  input  logic en,
  input  logic match,
  output logic hit
);

  localparam int            CW  = $clog2(MATCH_CNT + 1);
  localparam logic [CW-1:0] TOP = CW'(MATCH_CNT);

  logic [CW-1:0] cnt;

  // Count matching words; any mismatch while enabled restarts the run.
  always_ff @(posedge adc_clk_bufr) begin
    if (!rst_sync_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (!match)
        cnt <= '0;
      else if (cnt != TOP)
        cnt <= cnt + CW'(1);
    end
  end

  assign hit = (cnt == TOP);

endmodule

// File: rtl/adc_bitslip_train.sv
// Word-alignment trainer for one ADC lane in the adc_clk_bufr domain.
// Issues BITSLIP pulses until TRAIN_PATTERN is seen MATCH_CNT times in a row.
// Optional feature: define ADC_TRAIN_TAPSCAN_EN to step the data IODELAY after
// all bitslip positions fail; otherwise tap outputs are tied low.
//
//  state  | meaning
//  IDLE   | after reset, waiting for train_start
//  WAIT   | settle timer running after start/slip/tap step, data ignored
//  CHECK  | comparing data_in with TRAIN_PATTERN every cycle
//  SLIP   | bitslip pulse high this cycle
//  TAP    | iodelay_ce pulse high this cycle (tap-scan builds only)
//  LOCKED | lane aligned, train_done high
//  FAIL   | search exhausted, train_fail high
module adc_bitslip_train
  import adc_bitslip_train_pkg::*;
#(
  parameter int                DATA_W         = DEF_DATA_W,
  parameter logic [DATA_W-1:0] TRAIN_PATTERN  = DEF_TRAIN_PATTERN,
  parameter int                SLIP_WAIT      = DEF_SLIP_WAIT,
  parameter int                MATCH_CNT      = DEF_MATCH_CNT,
  parameter int                CNTVALUE_WIDTH = 5,
  parameter int                TAP_MAX        = 31
) (
  input  logic                       adc_clk_bufr,
  input  logic                       rst_sync_n,
  input  logic                       train_start,
  input  logic [DATA_W-1:0]          data_in,
  output logic                       bitslip,
  output logic                       iodelay_ce,
  output logic                       iodelay_inc,
  output logic [CNTVALUE_WIDTH-1:0]  tap_cnt,
  output logic [$clog2(DATA_W)-1:0]  slip_cnt,
  output logic                       train_done,
  output logic                       train_fail
);

  localparam int                   SLIP_W    = $clog2(DATA_W);
  localparam logic [SLIP_W-1:0]    SLIP_LAST = SLIP_W'(DATA_W - 1);
  localparam int                   TMR_W     = $clog2(SLIP_WAIT + 1);
  localparam logic [TMR_W-1:0]     TMR_LOAD  = TMR_W'(SLIP_WAIT - 1);

  train_state_e     state, state_nxt;
  logic [TMR_W-1:0] tmr;
  logic             hit;
  logic             match;

  assign match = (data_in == TRAIN_PATTERN);

  adc_match_cnt #(
    .MATCH_CNT (MATCH_CNT)
  ) u_match_cnt (
    .adc_clk_bufr (adc_clk_bufr),
    .rst_sync_n   (rst_sync_n),
    .clr          (train_start),
    .en           (state == ST_CHECK),
    .match        (match),
    .hit          (hit)
  );

  // Next-state decode; train_start overrides every state.
  always_comb begin
    state_nxt = state;
    if (train_start) begin
      state_nxt = ST_WAIT;
    end else begin
      case (state)
        ST_IDLE:   state_nxt = ST_IDLE;
        ST_WAIT:   if (tmr == '0) state_nxt = ST_CHECK;
        ST_CHECK: begin
          if (hit)
            state_nxt = ST_LOCKED;
          else if (!match) begin
            if (slip_cnt != SLIP_LAST)
              state_nxt = ST_SLIP;
            else
`ifdef ADC_TRAIN_TAPSCAN_EN
              state_nxt = (tap_cnt != CNTVALUE_WIDTH'(TAP_MAX)) ? ST_TAP : ST_FAIL;
`else
              state_nxt = ST_FAIL;
`endif
          end
        end
        ST_SLIP:   state_nxt = ST_WAIT;
`ifdef ADC_TRAIN_TAPSCAN_EN
        ST_TAP:    state_nxt = ST_WAIT;
`endif
        ST_LOCKED: state_nxt = ST_LOCKED;
        ST_FAIL:   state_nxt = ST_FAIL;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register, settle down-counter, slip counter and registered status outputs.
  always_ff @(posedge adc_clk_bufr) begin
    if (!rst_sync_n) begin
      state      <= ST_IDLE;
      tmr        <= '0;
      slip_cnt   <= '0;
      bitslip    <= 1'b0;
      train_done <= 1'b0;
      train_fail <= 1'b0;
    end else begin
      state      <= state_nxt;
      bitslip    <= (state_nxt == ST_SLIP);
      train_done <= (state_nxt == ST_LOCKED);
      train_fail <= (state_nxt == ST_FAIL);

      if (state_nxt == ST_WAIT && (state != ST_WAIT || train_start))
        tmr <= TMR_LOAD;
      else if (tmr != '0)
        tmr <= tmr - TMR_W'(1);

      if (train_start)
        slip_cnt <= '0;
      else if (state_nxt == ST_SLIP)
        slip_cnt <= slip_cnt + SLIP_W'(1);
`ifdef ADC_TRAIN_TAPSCAN_EN
      else if (state_nxt == ST_TAP)
        slip_cnt <= '0;
`endif
    end
  end

`ifdef ADC_TRAIN_TAPSCAN_EN
  // IODELAY tap stepping: one increment pulse per TAP visit, saturating count.
  always_ff @(posedge adc_clk_bufr) begin
    if (!rst_sync_n) begin
      tap_cnt     <= '0;
      iodelay_ce  <= 1'b0;
      iodelay_inc <= 1'b0;
    end else begin
      iodelay_ce  <= (state_nxt == ST_TAP);
      iodelay_inc <= (state_nxt == ST_TAP);
      if (train_start)
        tap_cnt <= '0;
      else if (state_nxt == ST_TAP && tap_cnt != CNTVALUE_WIDTH'(TAP_MAX))
        tap_cnt <= tap_cnt + CNTVALUE_WIDTH'(1);
    end
  end
`else
  logic unused_tap_max;
  assign unused_tap_max = (TAP_MAX != 0);
  assign tap_cnt        = '0;
  assign iodelay_ce     = 1'b0;
  assign iodelay_inc    = 1'b0;
`endif

endmodule
